maj_popcount_act: RTL and testbench
===================================

MAJ_POPCOUNT_ACT -- requirements
Module: maj_popcount_act

Interface
REQ-001 Parameter N, default 9, SHALL set the number of majority bits accumulated per output neuron (N >= 2).
REQ-002 Parameter CW, default 4, SHALL set the count width, with CW >= clog2(N+1).
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-005 in_valid  input  1  SHALL indicate that m carries a valid majority bit from the upstream XNOR-majority stage.
REQ-006 m  input  1  SHALL be the registered majority output of the upstream stage.
REQ-007 in_ready  output  1  SHALL indicate that this block accepts m this cycle.
REQ-008 thr  input  CW  SHALL be the activation threshold for the current neuron.
REQ-009 clr  input  1  SHALL be a synchronous flush of the partial accumulation.
REQ-010 out_valid  output  1  SHALL indicate that out_count and out_act hold a completed neuron result.
REQ-011 out_ready  input  1  SHALL indicate that the downstream stage consumes the result this cycle.
REQ-012 out_count  output  CW  SHALL be the popcount of the N accepted bits.
REQ-013 out_act  output  1  SHALL be the binary activation: 1 iff out_count >= latched threshold.

Function
REQ-014 A bit SHALL be accepted on a cycle with in_valid && in_ready && !clr.
REQ-015 Internal state SHALL be idx (0..N-1), acc (CW bits) and thr_q (CW bits).
REQ-016 When accepting with idx == 0, the block SHALL latch thr into thr_q and set acc = m; thr is ignored on all other cycles.
REQ-017 When accepting with 0 < idx < N-1, the block SHALL set acc = acc + m and idx = idx + 1.
REQ-018 When accepting with idx == N-1, the block SHALL set, on the next edge, out_count = acc + m, out_act = ((acc + m) >= thr_q) and out_valid = 1, and SHALL wrap idx to 0.
REQ-019 Latency SHALL be exactly 1 cycle from acceptance of the final bit to out_valid high.
REQ-020 Arithmetic SHALL be unsigned, and acc SHALL never exceed N (no overflow for legal CW).
REQ-021 in_ready SHALL equal !(out_valid && !out_ready && idx == N-1); non-final bits are accepted even while a result is held.
REQ-022 out_valid SHALL clear on the edge where out_valid && out_ready, unless a new final bit is accepted that same cycle, in which case the new result loads with out_valid staying 1.
REQ-023 Outputs SHALL remain stable while out_valid && !out_ready.
REQ-024 When clr = 1, the block SHALL set idx = 0 and acc = 0 and drop any simultaneous input bit; out_valid, out_count and out_act SHALL be unaffected, and the out handshake SHALL proceed normally.
REQ-025 A cycle without acceptance SHALL leave idx, acc and thr_q unchanged.

Reset
REQ-026 While rst_n = 0, the block SHALL immediately force idx = 0, acc = 0, thr_q = 0, out_valid = 0, out_count = 0 and out_act = 0.
REQ-027 When rst_n = 0, in_ready SHALL read 1.
REQ-028 Reset asserted mid-neuron SHALL discard the partial sum; the first accepted bit after rst_n rises SHALL be idx 0 of a new neuron.

Verification
REQ-029 Scenario (N=9, thr=5, out_ready=1): stream 1,1,0,1,1,0,1,0,0 -> one cycle after the 9th bit, out_valid=1, out_count=5, out_act=1.
REQ-030 Scenario: same stream with thr=6 -> out_count=5, out_act=0; and thr changed to 0 at idx 3 -> result still uses 6.
REQ-031 Scenario (back-pressure): out_ready=0 with first result held, next neuron streams 8 bits -> all 8 are accepted; at the 9th bit in_ready=0 and outputs stay frozen; out_ready=1 -> second result appears the next cycle.
REQ-032 Scenario (back-to-back): 18 consecutive valid bits, all 1, thr=9, out_ready=1 -> two results of out_count=9, out_act=1, 9 cycles apart, with in_ready never low.
REQ-033 Scenario (clr): 4 bits of 1, then clr=1 with in_valid=1, m=1, then 9 bits of 0 -> out_count=0.
REQ-034 Scenario (reset): rst_n pulsed low asynchronously after 5 bits, with a result pending -> out_valid drops without waiting for a clock edge; a fresh 9-bit neuron yields a correct count.

Source files
------------

// File: rtl/maj_popcount_act_if.sv
// Handshake bundle between the XNOR-majority stage, the popcount/activation
// block and its downstream consumer.
interface maj_popcount_act_if #(
  parameter int CW = 4
);
  logic          in_valid;
  logic          m;
  logic          in_ready;
  logic [CW-1:0] thr;
  logic          clr;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;
  logic          out_act;

  modport master (
    output in_valid, m, thr, clr, out_ready,
    input  in_ready, out_valid, out_count, out_act
  );

  modport slave (
    input  in_valid, m, thr, clr, out_ready,
    output in_ready, out_valid, out_count, out_act
  );
endinterface

// File: rtl/maj_popcount_act.sv
// Accumulates N majority bits per neuron into a popcount and compares it
// against a threshold latched with the first bit to form a binary activation.
module maj_popcount_act #(
  parameter int N  = 9,
  parameter int CW = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  maj_popcount_act_if.slave   bus
);

  localparam int IW = (N > 2) ? $clog2(N) : 1;

  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [CW-1:0] thr_q, thr_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_count_q, out_count_d;
  logic          out_act_q, out_act_d;

  logic          last_idx;
  logic          accept;
  logic          out_fire;
  logic [CW-1:0] sum;

  assign last_idx = (idx_q == IW'(N - 1));
  // Only a final bit has to wait for a held result; earlier bits keep flowing.
  assign bus.in_ready = !(out_valid_q && !bus.out_ready && last_idx);
  assign accept       = bus.in_valid && bus.in_ready && !bus.clr;
  assign out_fire     = out_valid_q && bus.out_ready;
  assign sum          = acc_q + CW'(bus.m);

  always_comb begin
    idx_d       = idx_q;
    acc_d       = acc_q;
    thr_d       = thr_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_act_d   = out_act_q;

    if (bus.clr) begin
      idx_d = '0;
      acc_d = '0;
    end else if (accept) begin
      if (idx_q == '0) begin
        thr_d = bus.thr;
        acc_d = CW'(bus.m);
        idx_d = IW'(1);
      end else if (last_idx) begin
        idx_d = '0;
        acc_d = '0;
      end else begin
        acc_d = sum;
        idx_d = idx_q + IW'(1);
      end
    end

    // A final bit landing on the consume cycle replaces the result in place.
    if (accept && last_idx) begin
      out_valid_d = 1'b1;
      out_count_d = sum;
      out_act_d   = (sum >= thr_q);
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      acc_q       <= '0;
      thr_q       <= '0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_act_q   <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      thr_q       <= thr_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_act_q   <= out_act_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_count = out_count_q;
  assign bus.out_act   = out_act_q;

endmodule

// File: tb/tb_maj_popcount_act.sv
// Directed bench for maj_popcount_act (N=9, CW=4) with hand-computed results.
module tb_maj_popcount_act;

  localparam int N  = 9;
  localparam int CW = 4;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  maj_popcount_act_if #(.CW(CW)) bus ();

  maj_popcount_act #(.N(N), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one bit and leaves in_valid high so consecutive calls stream.
  task automatic send(input logic b, input bit chk_rdy);
    bus.in_valid = 1'b1;
    bus.m        = b;
    #1;
    if (chk_rdy) check("in_ready_stream", int'(bus.in_ready), 1);
    step();
  endtask

  task automatic check_out(input string tag, input int v, input int cnt, input int act);
    check({tag, "_valid"}, int'(bus.out_valid), v);
    check({tag, "_count"}, int'(bus.out_count), cnt);
    check({tag, "_act"},   int'(bus.out_act),   act);
  endtask

  logic s1 [9];

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.m         = 1'b0;
    bus.thr       = '0;
    bus.clr       = 1'b0;
    bus.out_ready = 1'b1;
    s1 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    #12;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check_out("rst", 0, 0, 0);
    rst_n = 1'b1;
    step();

    // Basic stream, thr=5 -> count 5, act 1
    bus.thr = 4'd5;
    for (int i = 0; i < 9; i++) begin
      send(s1[i], 1'b0);
      if (i == 7) check("basic_not_yet_valid", int'(bus.out_valid), 0);
    end
    check_out("basic", 1, 5, 1);
    bus.in_valid = 1'b0;
    step();
    check("basic_consumed", int'(bus.out_valid), 0);

    // thr=6 latched at idx 0, changed to 0 at idx 3 -> act 0
    bus.thr = 4'd6;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) bus.thr = 4'd0;
      send(s1[i], 1'b0);
    end
    check_out("thr_latch", 1, 5, 0);
    bus.in_valid = 1'b0;
    step();

    // Back-pressure: hold result A (count 9), stream 8 bits of the next neuron
    bus.out_ready = 1'b0;
    bus.thr = 4'd3;
    for (int i = 0; i < 9; i++) send(1'b1, 1'b0);
    check_out("bp_first", 1, 9, 1);
    bus.thr = 4'd4;
    for (int i = 0; i < 8; i++) send(i[0] ? 1'b0 : 1'b1, 1'b1);
    bus.in_valid = 1'b1;
    bus.m        = 1'b1;
    #1;
    check("bp_final_blocked", int'(bus.in_ready), 0);
    step();
    step();
    check_out("bp_frozen", 1, 9, 1);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", int'(bus.in_ready), 1);
    step();
    check_out("bp_second", 1, 5, 1);
    bus.in_valid = 1'b0;
    step();
    check("bp_drained", int'(bus.out_valid), 0);

    // Back-to-back: 18 ones, thr=9
    bus.thr = 4'd9;
    for (int i = 0; i < 18; i++) begin
      bus.in_valid = 1'b1;
      bus.m        = 1'b1;
      #1;
      check("b2b_in_ready", int'(bus.in_ready), 1);
      step();
      if (i == 8 || i == 17) check_out("b2b_result", 1, 9, 1);
      else check("b2b_valid", int'(bus.out_valid), 0);
    end
    bus.in_valid = 1'b0;
    step();

    // clr flushes the partial sum and drops its own bit
    bus.thr = 4'd1;
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
    bus.clr = 1'b1;
    send(1'b1, 1'b0);
    bus.clr = 1'b0;
    for (int i = 0; i < 8; i++) send(1'b0, 1'b0);
    check("clr_no_early", int'(bus.out_valid), 0);
    send(1'b0, 1'b0);
    check_out("clr", 1, 0, 0);
    bus.in_valid = 1'b0;
    step();

    // Async reset mid-neuron with a pending result
    bus.out_ready = 1'b0;
    bus.thr = 4'd0;
    for (int i = 0; i < 9; i++) send(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
    bus.in_valid = 1'b0;
    check("rst_pending", int'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("rst_async", 0, 0, 0);
    check("rst_async_in_ready", int'(bus.in_ready), 1);
    #3;
    rst_n = 1'b1;
    step();
    bus.out_ready = 1'b1;
    bus.thr = 4'd3;
    for (int i = 0; i < 9; i++) send((i < 3 || i == 8) ? 1'b1 : 1'b0, 1'b0);
    check_out("post_rst", 1, 4, 1);
    bus.in_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
